// File: rtl/proc_io_fifo_pkg.sv
// rtl/proc_io_fifo_pkg.sv - shared constants and helpers for the buffered core I/O bridge
package proc_io_fifo_pkg;

    localparam int ERR_W        = 3;
    localparam int ERR_RD_STALL = 0;
    localparam int ERR_WR_STALL = 1;
    localparam int ERR_ADDR     = 2;

    // Channel-select width: at least one bit even for a single channel
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proc_io_fifo_if.sv
// rtl/proc_io_fifo_if.sv - core strobe and external stream signals of the I/O bridge
interface proc_io_fifo_if #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2
);
    localparam int AIW = proc_io_fifo_pkg::sel_w(NUIOIN);
    localparam int AOW = proc_io_fifo_pkg::sel_w(NUIOOU);

    logic [AIW-1:0]           addr_in;
    logic                     req_in;
    logic [NUBITS-1:0]        io_in;
    logic [AOW-1:0]           addr_out;
    logic                     out_en;
    logic [NUBITS-1:0]        io_out;
    logic                     stall;
    logic [NUIOIN*NUBITS-1:0] in_data;
    logic [NUIOIN-1:0]        in_valid;
    logic [NUIOIN-1:0]        in_ready;
    logic [NUIOOU*NUBITS-1:0] out_data;
    logic [NUIOOU-1:0]        out_valid;
    logic [NUIOOU-1:0]        out_ready;
    logic [2:0]               err;

    modport slave (
        input  addr_in, req_in, addr_out, out_en, io_out, in_data, in_valid, out_ready,
        output io_in, stall, in_ready, out_data, out_valid, err
    );

    modport master (
        output addr_in, req_in, addr_out, out_en, io_out, in_data, in_valid, out_ready,
        input  io_in, stall, in_ready, out_data, out_valid, err
    );

endinterface

// File: rtl/proc_io_fifo_io_fifo.sv
// rtl/proc_io_fifo_io_fifo.sv - synchronous first-word-fall-through FIFO, head reads 0 when empty
module io_fifo #(
    parameter int NBDATA = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [NBDATA-1:0] din,
    input  logic              pop,
    output logic [NBDATA-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [NBDATA-1:0] mem_q [DEPTH];
    logic [NBDATA-1:0] mem_d [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Accept only legal operations; pointers wrap modulo DEPTH by width
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTRW'(do_push);
        rd_ptr_d = rd_ptr_q + PTRW'(do_pop);
        count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    // Pointer and occupancy state; reset discards buffered words
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty masks stale contents on dout
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/proc_io_fifo.sv
// rtl/proc_io_fifo.sv - buffered bridge between core strobed I/O and external stream channels
module proc_io_fifo
    import proc_io_fifo_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    proc_io_fifo_if.slave  bus
);
    localparam int AIW = sel_w(NUIOIN);
    localparam int AOW = sel_w(NUIOOU);

    logic [NUBITS-1:0] in_head  [NUIOIN];
    logic [NUBITS-1:0] out_head [NUIOOU];
    logic [NUIOIN-1:0] in_full, in_empty, in_pop;
    logic [NUIOOU-1:0] out_full, out_empty, out_push, out_pop;

    logic              in_sel_ok, out_sel_ok;
    logic              sel_in_empty, sel_out_full;
    logic [NUBITS-1:0] sel_in_head;
    logic              rd_stall, wr_stall, addr_err;
    logic [ERR_W-1:0]  err_d, err_q;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        io_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (bus.in_valid[k] & ~in_full[k]),
            .din   (bus.in_data[k*NUBITS +: NUBITS]),
            .pop   (in_pop[k]),
            .dout  (in_head[k]),
            .full  (in_full[k]),
            .empty (in_empty[k])
        );
    end

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        io_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (out_push[k]),
            .din   (bus.io_out),
            .pop   (out_pop[k]),
            .dout  (out_head[k]),
            .full  (out_full[k]),
            .empty (out_empty[k])
        );
    end

    // Channel demux/mux; an address matching no channel leaves the *_sel_ok flags low
    always_comb begin
        in_sel_ok    = 1'b0;
        sel_in_empty = 1'b1;
        sel_in_head  = '0;
        in_pop       = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (bus.addr_in == AIW'(k)) begin
                in_sel_ok    = 1'b1;
                sel_in_empty = in_empty[k];
                sel_in_head  = in_head[k];
                in_pop[k]    = bus.req_in & ~in_empty[k];
            end
        end
        out_sel_ok   = 1'b0;
        sel_out_full = 1'b0;
        out_push     = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            if (bus.addr_out == AOW'(k)) begin
                out_sel_ok   = 1'b1;
                sel_out_full = out_full[k];
                out_push[k]  = bus.out_en & ~out_full[k];
            end
        end
        out_pop  = ~out_empty & bus.out_ready;
        rd_stall = bus.req_in & in_sel_ok & sel_in_empty;
        wr_stall = bus.out_en & out_sel_ok & sel_out_full;
        addr_err = (bus.req_in & ~in_sel_ok) | (bus.out_en & ~out_sel_ok);
    end

    // Drive the bridge outputs from FIFO status and heads
    always_comb begin
        bus.io_in     = sel_in_head;
        bus.stall     = rd_stall | wr_stall;
        bus.in_ready  = ~in_full;
        bus.out_valid = ~out_empty;
        bus.err       = err_q;
        bus.out_data  = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            bus.out_data[k*NUBITS +: NUBITS] = out_head[k];
        end
    end

    // Sticky error accumulation
    always_comb begin
        err_d = err_q;
        if (rd_stall) err_d[ERR_RD_STALL] = 1'b1;
        if (wr_stall) err_d[ERR_WR_STALL] = 1'b1;
        if (addr_err) err_d[ERR_ADDR]     = 1'b1;
    end

    // Error flags clear only on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule
